systolic_seq_ctrl: RTL

// - Sequencer for the NxN INT8 systolic multiply array. Runs one tile job on start.
// - Reads K columns of A and K rows of B from the tile buffers over a shared address bus.
// - Applies the diagonal skew: lane i is delayed i cycles, and idle lanes are zero-filled.
// - Pulses acc_clr before the feed, waits for the array to drain, then signals done.

---
 rtl/systolic_seq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// Tile-job sequencer for an NxN systolic array: address generation, diagonal skew with zero-fill,
// accumulator clear and drain timing. Define SYSTOLIC_SEQ_PERF_EN to add the busy/job perf counters.
module systolic_seq_ctrl #(
    parameter int N      = 32,
    parameter int DW     = 16,
    parameter int KMAX   = 256,
    parameter int PE_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [$clog2(KMAX+1)-1:0]   k_len,
    output logic                        busy,
    output logic                        done,
    output logic                        acc_clr,
    output logic                        rd_en,
    output logic [$clog2(KMAX)-1:0]     rd_addr,
    input  logic [N*DW-1:0]             a_rd_data,
    input  logic [N*DW-1:0]             b_rd_data,
    output logic [N*DW-1:0]             a_west,
    output logic [N*DW-1:0]             b_north
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]                 perf_busy_cyc,
    output logic [15:0]                 perf_jobs
`endif
);

    localparam int KW  = $clog2(KMAX + 1);
    localparam int AW  = $clog2(KMAX);
    localparam int D   = 2 * (N - 1) + PE_LAT;
    localparam int DCW = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   k_cnt;
    logic [AW-1:0]   k_last;
    logic [DCW-1:0]  d_cnt;
    logic [KW-1:0]   k_sat;
    logic [N-1:0]    vld;

    always_comb begin
        k_sat = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        acc_clr   = 1'b0;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (k_len != '0)) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                acc_clr   = 1'b1;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (k_cnt == k_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (d_cnt == DCW'(D - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // k_cnt stops on the last index instead of stepping past it, so rd_addr holds K-1
    // afterwards and never wraps when K equals KMAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt  <= '0;
            k_last <= '0;
            d_cnt  <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_CLEAR) begin
                k_last <= AW'(k_sat - KW'(1));
            end
            if (state == S_CLEAR) begin
                k_cnt <= '0;
            end else if (state == S_FEED && k_cnt != k_last) begin
                k_cnt <= k_cnt + AW'(1);
            end
            if (state == S_FEED) begin
                d_cnt <= '0;
            end else if (state == S_DRAIN) begin
                d_cnt <= d_cnt + DCW'(1);
            end
        end
    end

    assign rd_addr = k_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= rd_en;
            for (int unsigned i = 1; i < N; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Lane i data rides i raw registers; the matching valid bit zeroes it outside its slot.
    for (genvar g = 0; g < N; g++) begin : g_lane
        if (g == 0) begin : g_l0
            always_comb begin
                a_west[0 +: DW]  = vld[0] ? a_rd_data[0 +: DW] : '0;
                b_north[0 +: DW] = vld[0] ? b_rd_data[0 +: DW] : '0;
            end
        end else begin : g_ln
            logic [DW-1:0] a_sr [g];
            logic [DW-1:0] b_sr [g];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned s = 0; s < g; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_rd_data[g*DW +: DW];
                    b_sr[0] <= b_rd_data[g*DW +: DW];
                    for (int unsigned s = 1; s < g; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end

            always_comb begin
                a_west[g*DW +: DW]  = vld[g] ? a_sr[g-1] : '0;
                b_north[g*DW +: DW] = vld[g] ? b_sr[g-1] : '0;
            end
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cyc <= '0;
            perf_jobs     <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if (done) begin
                perf_jobs <= perf_jobs + 16'd1;
            end
        end
    end
`endif

endmodule
